// File: rtl/rst_gen.sv
`default_nettype none
// ============================================================================
// Module   : rst_gen
// Purpose  : Board-level active-low reset generator. Combines power-on
//            release, a debounced push-button, a software request pulse and
//            a watchdog timeout into one registered reset output. Enforces a
//            minimum low-pulse width and keeps a sticky cause mask.
// Ports    : clk            system clock
//            rst_n          asynchronous active-low power-on reset
//            i_key_n        raw push-button (active low, async, bouncy)
//            i_sw_rst_req   single-cycle software reset request
//            i_wdt_en       watchdog enable
//            i_wdt_kick     single-cycle watchdog service pulse
//            o_rst_n_out    generated reset, active low, registered
//            o_busy         1 while in POR or HOLD
//            o_rst_cause    sticky cause: [0]POR [1]key [2]sw [3]wdt
// Revision : 1.0  initial release
// ============================================================================
module rst_gen #(
  parameter int POR_CYC   = 1024,
  parameter int PULSE_CYC = 256,
  parameter int DB_CYC    = 1000000,
  parameter int WDT_CYC   = 16777216
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_key_n,
  input  logic       i_sw_rst_req,
  input  logic       i_wdt_en,
  input  logic       i_wdt_kick,
  output logic       o_rst_n_out,
  output logic       o_busy,
  output logic [3:0] o_rst_cause
);

  localparam int c_CNT_MAX = (POR_CYC > PULSE_CYC) ? POR_CYC : PULSE_CYC;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;
  localparam int c_DB_W    = $clog2(DB_CYC) + 1;
  localparam int c_WDT_W   = $clog2(WDT_CYC) + 1;

  localparam logic [c_CNT_W-1:0] c_POR_LAST   = c_CNT_W'(POR_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(PULSE_CYC - 1);
  localparam logic [c_DB_W-1:0]  c_DB_LAST    = c_DB_W'(DB_CYC - 1);
  localparam logic [c_WDT_W-1:0] c_WDT_LAST   = c_WDT_W'(WDT_CYC - 1);

  typedef enum logic [1:0] {
    ST_POR  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                 r_rst_n_out, w_rst_n_out_nxt;
  logic [3:0]           r_cause, w_cause_nxt;

  logic [1:0]           r_key_sync;
  logic                 r_db_level;
  logic [c_DB_W-1:0]    r_db_cnt;
  logic [c_WDT_W-1:0]   r_wdt_cnt;

  logic                 w_run;
  logic                 w_key_s;
  logic                 w_db_mismatch;
  logic                 w_db_done;
  logic                 w_key_trig;
  logic                 w_sw_trig;
  logic                 w_wdt_clr;
  logic                 w_wdt_trig;
  logic [3:0]           w_trig_mask;
  logic                 w_any_trig;

  assign w_run   = (r_state == ST_RUN);
  assign w_key_s = r_key_sync[1];

  // Debounce: the level only follows key_s after DB_CYC consecutive
  // mismatching cycles. The key trigger fires in the cycle the debounced
  // level is about to fall, so it lines up with the update edge.
  assign w_db_mismatch = (w_key_s != r_db_level);
  assign w_db_done     = (r_db_cnt == c_DB_LAST);
  assign w_key_trig    = w_run && w_db_mismatch && w_db_done && r_db_level;

  assign w_sw_trig = w_run && i_sw_rst_req;

  // A kick in the expiry cycle clears the counter and suppresses the trigger.
  assign w_wdt_clr  = !w_run || !i_wdt_en || i_wdt_kick;
  assign w_wdt_trig = !w_wdt_clr && (r_wdt_cnt == c_WDT_LAST);

  assign w_trig_mask = {w_wdt_trig, w_sw_trig, w_key_trig, 1'b0};
  assign w_any_trig  = |w_trig_mask;

  // Next-state / next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rst_n_out_nxt = r_rst_n_out;
    w_cause_nxt     = r_cause;
    case (r_state)
      ST_POR: begin
        if (r_cnt == c_POR_LAST) begin
          w_state_nxt     = ST_RUN;
          w_cnt_nxt       = '0;
          w_rst_n_out_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      ST_RUN: begin
        w_rst_n_out_nxt = 1'b1;
        if (w_any_trig) begin
          w_state_nxt     = ST_HOLD;
          w_cnt_nxt       = '0;
          w_rst_n_out_nxt = 1'b0;
          w_cause_nxt     = w_trig_mask;
        end
      end
      ST_HOLD: begin
        if (r_cnt == c_PULSE_LAST) begin
          w_state_nxt     = ST_RUN;
          w_cnt_nxt       = '0;
          w_rst_n_out_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = ST_POR;
        w_cnt_nxt       = '0;
        w_rst_n_out_nxt = 1'b0;
      end
    endcase
  end

  // FSM state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_POR;
      r_cnt       <= '0;
      r_rst_n_out <= 1'b0;
      r_cause     <= 4'b0001;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rst_n_out <= w_rst_n_out_nxt;
      r_cause     <= w_cause_nxt;
    end
  end

  // Key synchronizer and debouncer; runs in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_sync <= 2'b11;
      r_db_level <= 1'b1;
      r_db_cnt   <= '0;
    end else begin
      r_key_sync <= {r_key_sync[0], i_key_n};
      if (w_db_mismatch) begin
        if (w_db_done) begin
          r_db_level <= w_key_s;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + c_DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Watchdog counter; never wraps because expiry clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdt_cnt <= '0;
    end else if (w_wdt_clr || w_wdt_trig) begin
      r_wdt_cnt <= '0;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + c_WDT_W'(1);
    end
  end

  assign o_rst_n_out = r_rst_n_out;
  assign o_busy      = (r_state != ST_RUN);
  assign o_rst_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_rst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_gen
// Purpose  : Scoreboard bench for rst_gen. The driver pushes the expected
//            low pulse (start edge, end edge, cause) for every reset event it
//            provokes; the monitor measures each low pulse of o_rst_n_out
//            and compares it with the head of the queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_rst_gen;

  localparam int POR_CYC   = 16;
  localparam int PULSE_CYC = 8;
  localparam int DB_CYC    = 4;
  localparam int WDT_CYC   = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_n = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       wdt_en = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       rst_n_out;
  logic       busy;
  logic [3:0] rst_cause;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int         s;  // edge that drives the output low (-1: not checked)
    int         e;  // edge that releases the output
    logic [3:0] c;  // cause visible at release
  } pulse_t;

  pulse_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rst_gen #(
    .POR_CYC   (POR_CYC),
    .PULSE_CYC (PULSE_CYC),
    .DB_CYC    (DB_CYC),
    .WDT_CYC   (WDT_CYC)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_key_n      (key_n),
    .i_sw_rst_req (sw_rst_req),
    .i_wdt_en     (wdt_en),
    .i_wdt_kick   (wdt_kick),
    .o_rst_n_out  (rst_n_out),
    .o_busy       (busy),
    .o_rst_cause  (rst_cause)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int s, input int e, input logic [3:0] c);
    pulse_t p;
    p.s = s;
    p.e = e;
    p.c = c;
    exp_q.push_back(p);
  endfunction

  // Inputs change 2 time units after a rising edge; cyc then equals the
  // number of edges so far, and the value set is sampled at edge cyc+1.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) tick();
  endtask

  // Monitor: measures every low pulse of rst_n_out on the falling clock edge
  initial begin
    logic   prev;
    int     lo_start;
    pulse_t p;
    prev     = 1'b1;
    lo_start = 0;
    forever begin
      @(negedge clk);
      if (prev && !rst_n_out) begin
        lo_start = cyc;
        chk("busy_at_fall", int'(busy), 1);
      end else if (!prev && rst_n_out) begin
        chk("busy_at_rise", int'(busy), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_end", cyc, -1);
        end else begin
          p = exp_q.pop_front();
          if (p.s >= 0) chk("pulse_start", lo_start, p.s);
          chk("pulse_end", cyc, p.e);
          chk("pulse_cause", int'(rst_cause), int'(p.c));
        end
      end
      prev = rst_n_out;
    end
  end

  // Driver
  initial begin
    int k0, a, s, d, r, r2, k, e, f;
    #1 rst_n = 1'b0;
    tick(3);
    chk("reset_rst_n_out", int'(rst_n_out), 0);
    chk("reset_busy", int'(busy), 1);
    chk("reset_cause", int'(rst_cause), 1);

    // Power-on release
    rst_n = 1'b1;
    k0 = cyc;
    push(-1, k0 + POR_CYC, 4'b0001);
    wait_until(k0 + POR_CYC - 1);
    chk("por_last_low_cycle", int'(rst_n_out), 0);
    wait_until(k0 + POR_CYC + 3);

    // Software request in RUN
    a = cyc;
    sw_rst_req = 1'b1;
    push(a + 1, a + 1 + PULSE_CYC, 4'b0100);
    tick();
    sw_rst_req = 1'b0;
    wait_until(a + 1 + PULSE_CYC + 3);

    // Bouncing key, then held low: single trigger 2 sync + 4 debounce edges later
    repeat (5) begin
      key_n = 1'b0;
      tick(2);
      key_n = 1'b1;
      tick(2);
    end
    key_n = 1'b0;
    s = cyc;
    push(s + 2 + DB_CYC, s + 2 + DB_CYC + PULSE_CYC, 4'b0010);
    tick(50);
    key_n = 1'b1;
    tick(10);

    // Software request; watchdog enabled and a second request during HOLD
    d = cyc;
    sw_rst_req = 1'b1;
    push(d + 1, d + 1 + PULSE_CYC, 4'b0100);
    tick();
    sw_rst_req = 1'b0;
    tick();
    wdt_en = 1'b1;
    tick(2);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    r = d + 1 + PULSE_CYC;
    push(r + WDT_CYC, r + WDT_CYC + PULSE_CYC, 4'b1000);
    wait_until(r + WDT_CYC + PULSE_CYC);
    chk("wdt_hold_released", int'(rst_n_out), 1);

    // Regular kicks every 20 cycles for 500 cycles
    r2 = cyc;
    for (int i = 1; i <= 25; i++) begin
      wait_until(r2 + 20 * i - 1);
      wdt_kick = 1'b1;
      tick();
      wdt_kick = 1'b0;
    end
    k = r2 + 500;
    chk("kick_period_no_reset", int'(rst_n_out), 1);

    // Kick exactly in the expiry cycle
    wait_until(k + WDT_CYC - 1);
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;

    // Software request coincides with the next expiry
    wait_until(k + 2 * WDT_CYC - 1);
    chk("late_kick_no_reset", int'(rst_n_out), 1);
    sw_rst_req = 1'b1;
    push(k + 2 * WDT_CYC, k + 2 * WDT_CYC + PULSE_CYC, 4'b1100);
    tick();
    sw_rst_req = 1'b0;
    wait_until(k + 2 * WDT_CYC + PULSE_CYC + 2);
    wdt_en = 1'b0;
    tick(3);

    // rst_n asserted mid-HOLD restarts the power-on sequence
    e = cyc;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick();
    chk("midhold_reset_cause", int'(rst_cause), 1);
    chk("midhold_reset_busy", int'(busy), 1);
    chk("midhold_reset_out", int'(rst_n_out), 0);
    tick(2);
    rst_n = 1'b1;
    f = cyc;
    push(e + 1, f + POR_CYC, 4'b0001);
    wait_until(f + POR_CYC + 10);

    chk("final_rst_n_out", int'(rst_n_out), 1);
    chk("final_cause", int'(rst_cause), 1);
    chk("pending_expected_pulses", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
